// File: rtl/ssd_arb_pkg.sv
// Shared types, constants and slice helpers for the seven-segment display arbiter.
package ssd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        URGENT = 2'd2
    } arb_state_e;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam int unsigned N_DIGITS  = 8;

    // Nibble k of a 32-bit source word; k=0 feeds hex0.
    function automatic logic [3:0] nibble_of(input logic [31:0] word, input int unsigned k);
        return word[4*k +: 4];
    endfunction

endpackage

// File: rtl/ssd_display_arbiter_if.sv
// Request side and display side of the arbiter; slave is the arbiter itself.
interface ssd_display_arbiter_if #(
    parameter int unsigned N_SRC = 3
);
    logic [N_SRC-1:0]    src_req;
    logic [N_SRC*32-1:0] src_digits;
    logic [N_SRC*8-1:0]  src_dp;
    logic                urgent;
    logic [N_SRC-1:0]    grant;
    logic                switch_pulse;
    logic [6:0]          hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [7:0]          dpoints;

    modport master (
        output src_req, src_digits, src_dp, urgent,
        input  grant, switch_pulse, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, dpoints
    );

    modport slave (
        input  src_req, src_digits, src_dp, urgent,
        output grant, switch_pulse, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, dpoints
    );
endinterface

// File: rtl/ssd_display_arbiter_hex_to_sseg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment encoder.
module hex_to_sseg
    import ssd_arb_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin, minimum-dwell arbiter sharing the 8-digit display, with a blinking
// urgent override for source 0 and registered segment outputs.
module ssd_display_arbiter
    import ssd_arb_pkg::*;
#(
    parameter int unsigned N_SRC        = 3,
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter int unsigned BLINK_HALF   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    ssd_display_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W   = $clog2(N_SRC);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(N_SRC - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               switch_pulse_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // {found, index} of the first requester at or after start, wrapping at N_SRC.
    function automatic logic [PTR_W:0] find_next(input logic [N_SRC-1:0] req,
                                                 input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] hit;
        logic             found;
        idx   = start;
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                hit   = idx;
            end
            idx = ptr_inc(idx);
        end
        return {found, hit};
    endfunction

    logic             urgent_req_c, others_c, enter_urgent_c, sel_rr_c, sel_g_c;
    logic [PTR_W:0]   nxt_rr_c, nxt_g_c, nxt_c;

    always_comb begin
        state_d        = state_q;
        gidx_d         = gidx_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        dwell_d        = dwell_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        enter_urgent_c = 1'b0;
        sel_rr_c       = 1'b0;
        sel_g_c        = 1'b0;
        urgent_req_c   = bus.urgent & bus.src_req[0];
        others_c       = |(bus.src_req & ~grant_q);
        nxt_rr_c       = find_next(bus.src_req, rr_ptr_q);
        nxt_g_c        = find_next(bus.src_req, ptr_inc(gidx_q));

        case (state_q)
            IDLE: begin
                if (urgent_req_c) enter_urgent_c = 1'b1;
                else              sel_rr_c       = 1'b1;
            end
            SHOW: begin
                if (urgent_req_c)                            enter_urgent_c = 1'b1;
                else if (!bus.src_req[gidx_q])               sel_g_c        = 1'b1;
                else if (dwell_q == DWELL_MAX && others_c)   sel_g_c        = 1'b1;
                else if (dwell_q != DWELL_MAX)               dwell_d        = dwell_q + DWELL_W'(1);
            end
            URGENT: begin
                if (!urgent_req_c) begin
                    sel_rr_c = 1'b1;
                end else if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Apply the chosen transition; the urgent episode never moves rr_ptr.
        nxt_c = sel_g_c ? nxt_g_c : nxt_rr_c;
        if (enter_urgent_c) begin
            state_d       = URGENT;
            gidx_d        = '0;
            grant_d       = N_SRC'(1);
            dwell_d       = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (sel_rr_c || sel_g_c) begin
            dwell_d = '0;
            if (nxt_c[PTR_W]) begin
                state_d = SHOW;
                gidx_d  = nxt_c[PTR_W-1:0];
                grant_d = N_SRC'(1) << nxt_c[PTR_W-1:0];
                if (sel_g_c) rr_ptr_d = ptr_inc(nxt_c[PTR_W-1:0]);
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gidx_q         <= '0;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            dwell_q        <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gidx_q         <= gidx_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            dwell_q        <= dwell_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            switch_pulse_q <= (grant_d != grant_q);
        end
    end

    // Display path works from the registered grant, so it trails grant by one cycle.
    logic [31:0] shown_digits_c;
    logic [7:0]  shown_dp_c;
    logic        blank_c;
    logic [6:0]  seg_c [N_DIGITS];
    logic [6:0]  hex_q [N_DIGITS];
    logic [7:0]  dpoints_q;

    always_comb begin
        shown_digits_c = bus.src_digits[32'(gidx_q) * 32 +: 32];
        shown_dp_c     = bus.src_dp[32'(gidx_q) * 8 +: 8];
        blank_c        = (grant_q == '0) || (state_q == URGENT && blink_phase_q);
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_enc
        hex_to_sseg u_enc (
            .nibble (nibble_of(shown_digits_c, k)),
            .seg_c  (seg_c[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(N_DIGITS); k++) hex_q[k] <= SEG_BLANK;
            dpoints_q <= '0;
        end else begin
            for (int k = 0; k < int'(N_DIGITS); k++) hex_q[k] <= blank_c ? SEG_BLANK : seg_c[k];
            dpoints_q <= blank_c ? 8'h00 : shown_dp_c;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.switch_pulse = switch_pulse_q;
    assign bus.hex0         = hex_q[0];
    assign bus.hex1         = hex_q[1];
    assign bus.hex2         = hex_q[2];
    assign bus.hex3         = hex_q[3];
    assign bus.hex4         = hex_q[4];
    assign bus.hex5         = hex_q[5];
    assign bus.hex6         = hex_q[6];
    assign bus.hex7         = hex_q[7];
    assign bus.dpoints      = dpoints_q;

endmodule
